segdecode_spi_master: RTL and testbench
=======================================

Name: segdecode_spi_master

Overview:
- SPI initiator that drives the 7-segment/keypad decoder slave from the other end of its link.
- Scans four display positions continuously. Each position gets one 8-bit frame: keypad column select [7:6], screen select [5:4], hex digit [3:0], sent MSB first.
- After each frame the block samples the slave's MISO (keypad column state), so one sweep returns four key bits.
- Sits in the host-side controller in place of the microcontroller's bit-banged SPI.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).
- GAP_CYC, 4, clk cycles EN is held low after each frame before MISO is sampled (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- scan_en  input  1  1 = run sweeps back-to-back; 0 = stop at end of current sweep.
- digits  input  16  digit k at [4k+3:4k], k=0..3.
- miso  input  1  slave MISO; low = key in selected column pressed.
- sck  output  1  SPI clock, idle low.
- mosi  output  1  SPI data; slave samples on sck rising edge.
- spi_en  output  1  slave enable, active-high. The slave latches the frame on its falling edge.
- keys  output  4  key bit k = ~miso sampled after frame k of the last completed sweep.
- keys_valid  output  1  one-cycle pulse when keys updates.
- busy  output  1  high while any sweep is in progress.

Behaviour:
- Reset values: sck=0, mosi=0, spi_en=0, keys=0, keys_valid=0, busy=0; FSM=IDLE, counters cleared.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
- IDLE:
  - If scan_en=1: snapshot digits into an internal register (no tearing mid-sweep), frame index f=0, busy=1.
  - Go to SETUP.
- SETUP (CLK_DIV cycles):
  - spi_en=1, sck=0.
  - Shift reg = {f[1:0], f[1:0], dig[f]}; mosi = bit7.
  - Then HIGH.
- HIGH (CLK_DIV cycles): sck=1. Then LOW.
- LOW (CLK_DIV cycles):
  - sck=0; mosi advances to the next bit on the first LOW cycle.
  - After the LOW that follows bit 0: go to GAP (8 HIGH phases total).
  - Otherwise go to HIGH.
- GAP (GAP_CYC cycles):
  - spi_en=0, mosi=0.
  - On the last GAP cycle: capture key_tmp[f] = ~miso.
  - If f=3: keys <= key_tmp with bit3 = ~miso; keys_valid=1 for one cycle. Then:
    - scan_en=1: resnapshot digits, f=0, SETUP.
    - scan_en=0: IDLE, busy=0 the same cycle keys_valid pulses.
  - Else: f=f+1, SETUP.
- Frame length = 17*CLK_DIV + GAP_CYC clk cycles (38 at defaults). Sweep = 4 frames (152 cycles).
- scan_en deasserted mid-sweep: sweep completes normally; no partial keys update.
- scan_en changes are ignored except at sweep boundaries (IDLE or end of GAP with f=3).
- rst mid-frame:
  - All outputs return to reset values on the next edge.
  - spi_en dropping may latch a partial frame in the slave; accepted, because the next sweep rewrites all positions.
  - keys cleared.
- Only one sck rising edge per bit. mosi is stable for CLK_DIV cycles before and after each rising edge.
- Counters: div counter of width clog2(CLK_DIV max(GAP_CYC)); 3-bit bit counter; 2-bit frame index that wraps 3->0.

Decomposition:
- Shared package segdecode_pkg:
  - FSM state enum.
  - Frame field offsets: COL_MSB=7, COL_LSB=6, SCR_MSB=5, SCR_LSB=4, DIG_MSB=3, DIG_LSB=0.
  - FRAME_BITS=8; NUM_POS=4.
- One natural sub-module: segdecode_spi_shifter (8-bit parallel-load MSB-first shift register with load/shift strobes).
- FSM, divider and key capture stay in the top.

Test Plan:
- Reset then scan_en=1, digits=16'h4321, slave model attached:
  - Slave dOUT sequence per frame is 0x01, 0x52, 0xA3, 0xF4.
  - spi_en low pulse every 38 cycles.
  - busy=1.
- Bit timing, CLK_DIV=2: exactly 8 sck rising edges per spi_en-high window.
  - mosi stable for 2 cycles each side of every edge.
  - sck=0 while spi_en=0.
- Keypad: slave KeyPlxr=4'b0100 (column 2 pressed, MISO low for col 2):
  - After first sweep keys=4'b0100 with one keys_valid pulse at cycle 152 from start.
- Stop: scan_en dropped during frame 1:
  - Frames 2 and 3 still sent; keys_valid pulses once; busy falls the same cycle; FSM then stays IDLE.
- Digit change mid-sweep: digits changed from 16'h4321 to 16'hFFFF during frame 1:
  - Frames 2/3 still carry 3 and 4.
  - Next sweep carries 0x0F, 0x5F, 0xAF, 0xFF.
- Reset asserted mid-frame (bit 4 of frame 2):
  - Next edge: sck=0, spi_en=0, keys=0, busy=0.
  - After release with scan_en=1, the sweep restarts at frame 0.

Source files
------------

// File: rtl/segdecode_pkg.sv
// ---------------------------------------------------------------------------
// segdecode_pkg
//   Shared definitions for the segment/keypad decoder SPI initiator:
//   FSM state encoding, frame field layout and small frame-building helpers.
//   No ports (package).
// ---------------------------------------------------------------------------
package segdecode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } state_e;

    // Frame layout: {column select, screen select, hex digit}, sent MSB first.
    localparam int COL_MSB    = 7;
    localparam int COL_LSB    = 6;
    localparam int SCR_MSB    = 5;
    localparam int SCR_LSB    = 4;
    localparam int DIG_MSB    = 3;
    localparam int DIG_LSB    = 0;
    localparam int FRAME_BITS = 8;
    localparam int NUM_POS    = 4;

    // Position k drives keypad column k and screen k with digit k.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pos,
                                                          input logic [3:0] digit);
        logic [FRAME_BITS-1:0] frame;
        frame                  = '0;
        frame[COL_MSB:COL_LSB] = pos;
        frame[SCR_MSB:SCR_LSB] = pos;
        frame[DIG_MSB:DIG_LSB] = digit;
        return frame;
    endfunction

    // Digit k lives at [4k+3:4k] of the packed digit word.
    function automatic logic [3:0] digit_sel(input logic [4*NUM_POS-1:0] digits,
                                             input logic [1:0]           pos);
        return digits[{pos, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/segdecode_spi_master_if.sv
// ---------------------------------------------------------------------------
// segdecode_spi_master_if
//   SPI link between the host-side initiator and the decoder slave.
//   sck    : SPI clock, idle low
//   mosi   : initiator data, sampled by the slave on sck rising edge
//   spi_en : slave enable, active-high; slave latches the frame on its fall
//   miso   : slave keypad column state, low = key pressed
// ---------------------------------------------------------------------------
interface segdecode_spi_master_if;

    logic sck;
    logic mosi;
    logic spi_en;
    logic miso;

    modport master (
        output sck,
        output mosi,
        output spi_en,
        input  miso
    );

    modport slave (
        input  sck,
        input  mosi,
        input  spi_en,
        output miso
    );

endinterface

// File: rtl/segdecode_spi_shifter.sv
// ---------------------------------------------------------------------------
// segdecode_spi_shifter
//   8-bit parallel-load, MSB-first shift register feeding MOSI.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   load_i  : load data_i (has priority over shift_i)
//   shift_i : shift left by one, zero fill
//   data_i  : parallel frame to load
//   msb_o   : current MSB, i.e. the bit on the wire
// ---------------------------------------------------------------------------
module segdecode_spi_shifter
    import segdecode_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [FRAME_BITS-1:0] data_i,
    output logic                  msb_o
);

    logic [FRAME_BITS-1:0] sr_q;
    logic [FRAME_BITS-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[FRAME_BITS-1];

endmodule

// File: rtl/segdecode_spi_master.sv
// ---------------------------------------------------------------------------
// segdecode_spi_master
//   SPI initiator for the 7-segment/keypad decoder slave. Sweeps four display
//   positions, one 8-bit frame each, and samples MISO after every frame to
//   collect one key bit per keypad column.
//   clk          : system clock, rising edge
//   rst          : synchronous reset, active-high
//   scan_en_i    : 1 = sweep back-to-back, 0 = stop at the end of this sweep
//   digits_i     : digit k at [4k+3:4k]
//   keys_o       : key bit k = ~miso sampled after frame k of the last sweep
//   keys_valid_o : one-cycle pulse when keys_o updates
//   busy_o       : high while a sweep is in progress
//   spi          : SPI link (master modport)
// ---------------------------------------------------------------------------
module segdecode_spi_master
    import segdecode_pkg::*;
#(
    parameter int CLK_DIV = 2,   // clk cycles per SCK half-period, >= 1
    parameter int GAP_CYC = 4    // clk cycles EN is low after a frame, >= 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_en_i,
    input  logic [4*NUM_POS-1:0]   digits_i,
    output logic [NUM_POS-1:0]     keys_o,
    output logic                   keys_valid_o,
    output logic                   busy_o,
    segdecode_spi_master_if.master spi
);

    localparam int                CNT_MAX    = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int                DIV_W      = $clog2(CNT_MAX);
    localparam logic [DIV_W-1:0]  PHASE_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  GAP_LAST   = DIV_W'(GAP_CYC - 1);

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [2:0]             bit_q, bit_d;
    logic [1:0]             frame_q, frame_d;
    logic [4*NUM_POS-1:0]   dig_q, dig_d;
    logic [NUM_POS-1:0]     key_tmp_q, key_tmp_d;
    logic [NUM_POS-1:0]     keys_q, keys_d;
    logic                   keys_valid_q, keys_valid_d;
    logic                   busy_q, busy_d;

    logic                   sr_load;
    logic                   sr_shift;
    logic [FRAME_BITS-1:0]  sr_data;
    logic                   sr_msb;
    logic                   frame_active;

    segdecode_spi_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_data),
        .msb_o   (sr_msb)
    );

    // NOTE: every signal gets its default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        frame_d      = frame_q;
        dig_d        = dig_q;
        key_tmp_d    = key_tmp_q;
        keys_d       = keys_q;
        keys_valid_d = 1'b0;
        busy_d       = busy_q;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_data      = '0;

        case (state_q)
            IDLE: begin
                if (scan_en_i) begin
                    // Snapshot the digits so a sweep never mixes old and new.
                    dig_d   = digits_i;
                    frame_d = 2'd0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    sr_load = 1'b1;
                    sr_data = build_frame(2'd0, digit_sel(digits_i, 2'd0));
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (div_q == PHASE_LAST) begin
                    div_d   = '0;
                    state_d = HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HIGH: begin
                if (div_q == PHASE_LAST) begin
                    div_d    = '0;
                    // Advance mosi as sck falls, so it is stable around each rise.
                    sr_shift = 1'b1;
                    state_d  = LOW;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            LOW: begin
                if (div_q == PHASE_LAST) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = HIGH;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d              = '0;
                    // The slave has settled MISO for this column by now.
                    key_tmp_d[frame_q] = ~spi.miso;
                    if (frame_q == 2'd3) begin
                        keys_d       = key_tmp_d;
                        keys_valid_d = 1'b1;
                        if (scan_en_i) begin
                            dig_d   = digits_i;
                            frame_d = 2'd0;
                            sr_load = 1'b1;
                            sr_data = build_frame(2'd0, digit_sel(digits_i, 2'd0));
                            state_d = SETUP;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        frame_d = frame_q + 2'd1;
                        sr_load = 1'b1;
                        sr_data = build_frame(frame_q + 2'd1,
                                              digit_sel(dig_q, frame_q + 2'd1));
                        state_d = SETUP;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update
    // together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            frame_q      <= '0;
            dig_q        <= '0;
            key_tmp_q    <= '0;
            keys_q       <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            frame_q      <= frame_d;
            dig_q        <= dig_d;
            key_tmp_q    <= key_tmp_d;
            keys_q       <= keys_d;
            keys_valid_q <= keys_valid_d;
            busy_q       <= busy_d;
        end
    end

    // SPI pins decode straight from the registered state, so reset forces
    // them idle on the very next edge.
    assign frame_active = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);
    assign spi.spi_en   = frame_active;
    assign spi.sck      = (state_q == HIGH);
    assign spi.mosi     = frame_active & sr_msb;

    assign keys_o       = keys_q;
    assign keys_valid_o = keys_valid_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_segdecode_spi_master.sv
module tb_segdecode_spi_master;

    localparam int CLK_DIV   = 2;
    localparam int GAP_CYC   = 4;
    localparam int FRAME_CYC = 17 * CLK_DIV + GAP_CYC;   // 38
    localparam int SWEEP_CYC = 4 * FRAME_CYC;            // 152
    localparam int BUDGET    = 2000;
    localparam int CLK_PER   = 10;

    typedef struct {
        logic [15:0]      digits;
        logic [3:0]       plxr;     // slave keypad: 1 = key in column k pressed
        logic [3:0][7:0]  frames;   // frames[k] = byte latched by the slave for frame k
        logic [3:0]       keys;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        scan_en = 1'b0;
    logic [15:0] digits  = '0;
    logic [3:0]  keys;
    logic        keys_valid;
    logic        busy;

    segdecode_spi_master_if spi_if ();

    segdecode_spi_master #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_en_i    (scan_en),
        .digits_i     (digits),
        .keys_o       (keys),
        .keys_valid_o (keys_valid),
        .busy_o       (busy),
        .spi          (spi_if)
    );

    always #(CLK_PER / 2) clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [3:0] key_plxr = '0;
    logic       miso_drv = 1'b1;
    logic [7:0] slv_sr   = '0;
    logic [7:0] frames[$];
    time        fall_t[$];
    int         win_rises = 0;

    assign spi_if.miso = miso_drv;

    always @(posedge spi_if.sck) begin
        if (spi_if.spi_en) begin
            slv_sr = {slv_sr[6:0], spi_if.mosi};
            win_rises++;
        end
    end

    always @(posedge spi_if.spi_en) win_rises = 0;

    always @(negedge spi_if.spi_en) begin
        frames.push_back(slv_sr);
        fall_t.push_back($time);
        miso_drv = ~key_plxr[slv_sr[7:6]];
    end

    // ---------------- bit-timing monitor ----------------
    bit   mon_on     = 1'b0;
    int   viol       = 0;
    int   windows    = 0;
    int   edges      = 0;
    int   since_chg  = 1000;
    int   since_rise = 1000;
    logic p_mosi     = 1'b0;
    logic p_sck      = 1'b0;
    logic p_en       = 1'b0;

    always @(negedge clk) begin
        logic chg;
        logic rise;
        chg  = (spi_if.mosi !== p_mosi);
        rise = spi_if.sck && !p_sck;
        if (spi_if.spi_en && !p_en) edges = 0;
        if (mon_on) begin
            if (spi_if.sck && !spi_if.spi_en) viol++;
            if (rise) begin
                if (chg || since_chg < CLK_DIV) viol++;
                if (spi_if.spi_en) edges++;
            end else if (chg && since_rise + 1 < CLK_DIV) begin
                viol++;
            end
            if (!spi_if.spi_en && p_en) begin
                if (edges != 8) viol++;
                windows++;
            end
        end
        if (rise) since_rise = 0;
        else if (since_rise < 1000) since_rise++;
        if (chg) since_chg = 1;
        else if (since_chg < 1000) since_chg++;
        p_mosi = spi_if.mosi;
        p_sck  = spi_if.sck;
        p_en   = spi_if.spi_en;
    end

    initial begin
        #(CLK_PER * 20000);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t vec[4];
        int   n;
        int   t;
        int   pulses;
        int   en_hi;
        logic [7:0] exp8[8];

        vec[0] = '{digits: 16'h4321, plxr: 4'b0100,
                   frames: {8'hF4, 8'hA3, 8'h52, 8'h01}, keys: 4'b0100};
        vec[1] = '{digits: 16'hFFFF, plxr: 4'b0000,
                   frames: {8'hFF, 8'hAF, 8'h5F, 8'h0F}, keys: 4'b0000};
        vec[2] = '{digits: 16'h0A5C, plxr: 4'b1011,
                   frames: {8'hF0, 8'hAA, 8'h55, 8'h0C}, keys: 4'b1011};
        vec[3] = '{digits: 16'h9E07, plxr: 4'b1111,
                   frames: {8'hF9, 8'hAE, 8'h50, 8'h07}, keys: 4'b1111};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sck", spi_if.sck, 1'b0);
        check("rst_mosi", spi_if.mosi, 1'b0);
        check("rst_spi_en", spi_if.spi_en, 1'b0);
        check("rst_keys", keys, 4'b0000);
        check("rst_keys_valid", keys_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst    = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_spi_en", spi_if.spi_en, 1'b0);

        // Table-driven single sweeps, scan_en dropped during frame 1
        for (int v = 0; v < 4; v++) begin
            digits   = vec[v].digits;
            key_plxr = vec[v].plxr;
            frames.delete();
            fall_t.delete();
            scan_en = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!busy && n < BUDGET);
            check($sformatf("v%0d_busy_rise", v), busy, 1'b1);
            t = 0;
            while (!keys_valid && t < BUDGET) begin
                @(negedge clk);
                t++;
                if (t == FRAME_CYC + 10) scan_en = 1'b0;
            end
            check($sformatf("v%0d_sweep_len", v), t, SWEEP_CYC);
            check($sformatf("v%0d_busy_at_valid", v), busy, 1'b0);
            check($sformatf("v%0d_keys", v), keys, vec[v].keys);
            pulses = 0;
            en_hi  = 0;
            repeat (20) begin
                @(negedge clk);
                pulses += int'(keys_valid);
                en_hi  += int'(spi_if.spi_en);
            end
            check($sformatf("v%0d_extra_pulses", v), pulses, 0);
            check($sformatf("v%0d_stays_idle", v), en_hi, 0);
            check($sformatf("v%0d_nframes", v), frames.size(), 4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("v%0d_frame%0d", v, k),
                      (k < frames.size()) ? frames[k] : 8'hxx, vec[v].frames[k]);
            end
            if (v == 0 && fall_t.size() == 4) begin
                for (int k = 1; k < 4; k++) begin
                    check($sformatf("frame_period%0d", k),
                          32'(fall_t[k] - fall_t[k-1]), FRAME_CYC * CLK_PER);
                end
            end
        end

        // Digit change mid-sweep, back-to-back sweeps
        digits   = 16'h4321;
        key_plxr = 4'b0100;
        frames.delete();
        fall_t.delete();
        scan_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < BUDGET);
        check("dc_busy_rise", busy, 1'b1);
        t      = 0;
        pulses = 0;
        while (t < 2 * SWEEP_CYC + 20) begin
            @(negedge clk);
            t++;
            pulses += int'(keys_valid);
            if (t == FRAME_CYC + 10) digits = 16'hFFFF;
            if (t == SWEEP_CYC + FRAME_CYC + 10) scan_en = 1'b0;
        end
        check("dc_pulses", pulses, 2);
        check("dc_busy_end", busy, 1'b0);
        check("dc_keys", keys, 4'b0100);
        check("dc_nframes", frames.size(), 8);
        exp8 = '{8'h01, 8'h52, 8'hA3, 8'hF4, 8'h0F, 8'h5F, 8'hAF, 8'hFF};
        for (int k = 0; k < 8; k++) begin
            check($sformatf("dc_frame%0d", k),
                  (k < frames.size()) ? frames[k] : 8'hxx, exp8[k]);
        end
        check("dc_boundary_period",
              (fall_t.size() >= 5) ? 32'(fall_t[4] - fall_t[3]) : 32'hFFFF_FFFF,
              FRAME_CYC * CLK_PER);

        // Reset at bit 4 of frame 2
        check("pre_rst_keys", keys, 4'b0100);
        mon_on   = 1'b0;
        digits   = 16'h4321;
        key_plxr = 4'b0100;
        frames.delete();
        scan_en = 1'b1;
        n = 0;
        while (!(frames.size() == 2 && win_rises == 4) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_f2b4", n < BUDGET, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_sck", spi_if.sck, 1'b0);
        check("mid_rst_spi_en", spi_if.spi_en, 1'b0);
        check("mid_rst_mosi", spi_if.mosi, 1'b0);
        check("mid_rst_keys", keys, 4'b0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_keys_valid", keys_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        frames.delete();
        fall_t.delete();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < BUDGET);
        check("post_rst_busy", busy, 1'b1);
        t = 0;
        while (!keys_valid && t < BUDGET) begin
            @(negedge clk);
            t++;
            if (t == FRAME_CYC + 10) scan_en = 1'b0;
        end
        check("post_rst_sweep_len", t, SWEEP_CYC);
        check("post_rst_keys", keys, 4'b0100);
        check("post_rst_nframes", frames.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_rst_frame%0d", k),
                  (k < frames.size()) ? frames[k] : 8'hxx, vec[0].frames[k]);
        end

        // Bit timing across all monitored windows (16 table + 8 digit-change)
        check("timing_violations", viol, 0);
        check("timing_windows", windows, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
